// File: rtl/demux_7_reg_if.sv
// Source-side handshake bundle for demux_7_reg: word/selector in, per-destination
// valid/ready out.
interface demux_7_reg_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       seletor;
  logic [WIDTH-1:0] data_in;
  logic [6:0]       dst_ready;
  logic [6:0]       out_valid;

  modport master (
    output in_valid, seletor, data_in, dst_ready,
    input  in_ready, out_valid
  );

  modport slave (
    input  in_valid, seletor, data_in, dst_ready,
    output in_ready, out_valid
  );
endinterface

// File: rtl/demux_7_reg.sv
// Write-side 7-way demux: accepts one word, stores it in the selected destination
// register, then holds out_valid until that destination accepts or the wait expires.
module demux_7_reg #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  demux_7_reg_if.slave     bus,
  output logic [WIDTH-1:0] out_0,
  output logic [WIDTH-1:0] out_1,
  output logic [WIDTH-1:0] out_2,
  output logic [WIDTH-1:0] out_3,
  output logic [WIDTH-1:0] out_4,
  output logic [WIDTH-1:0] out_5,
  output logic [WIDTH-1:0] out_6,
  output logic             err_timeout,
  output logic [7:0]       drop_count
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [2:0]       SEL_NULL  = 3'd7;

  typedef enum logic {
    IDLE,
    DRIVE
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       sel_q;
  logic [CNT_W-1:0] wait_q;
  logic [WIDTH-1:0] regs [7];
  logic             accept, complete, abort;

  // NOTE: every signal assigned here gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    state_d       = state_q;
    accept        = 1'b0;
    complete      = 1'b0;
    abort         = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = '0;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          accept = 1'b1;
          if (bus.seletor != SEL_NULL) state_d = DRIVE;
        end
      end
      DRIVE: begin
        bus.out_valid = 7'b1 << sel_q;
        // Completion is tested first so ready on the last wait cycle is not an error.
        if (bus.dst_ready[sel_q]) begin
          complete = 1'b1;
          state_d  = IDLE;
        end else if (wait_q == WAIT_LAST) begin
          abort   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: the destination registers are reset because their cleared value is architecturally visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q       <= '0;
      wait_q      <= '0;
      err_timeout <= 1'b0;
      drop_count  <= '0;
      for (int k = 0; k < 7; k++) regs[k] <= '0;
    end else begin
      if (accept) begin
        if (bus.seletor == SEL_NULL) begin
          if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
        end else begin
          sel_q  <= bus.seletor;
          wait_q <= '0;
          for (int k = 0; k < 7; k++)
            if (bus.seletor == 3'(k)) regs[k] <= bus.data_in;
        end
      end
      if (state_q == DRIVE && !complete && !abort) wait_q <= wait_q + 1'b1;
      if (abort) err_timeout <= 1'b1;
    end
  end

  assign out_0 = regs[0];
  assign out_1 = regs[1];
  assign out_2 = regs[2];
  assign out_3 = regs[3];
  assign out_4 = regs[4];
  assign out_5 = regs[5];
  assign out_6 = regs[6];

endmodule
